mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory stage of the 5-stage RV32I core; receives the execute-stage results and performs the data-memory access over a single-outstanding req/ack data bus. Generates byte strobes for stores and aligns and sign/zero-extends load data. Stalls the pipeline while a bus transaction is outstanding and passes writeback control through to the writeback stage.

Parameters:
TIMEOUT_CYCLES, 64, max cycles waiting for dbus_ack before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute-stage result valid
in_ready  out  1  stage can accept; low = stall upstream
flush  in  1  kill the op held in this stage (trap/redirect)
alu_result  in  32  effective address / ALU result
rs2_data  in  32  store data
mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mem_sel  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
wb_sel_in  in  2  writeback source select, passed through
rd_in  in  5  destination register
reg_we_in  in  1  register write enable
pc_next_in  in  32  pc+4, passed through
dbus_req  out  1  bus request; held until ack
dbus_we  out  1  1 = store
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_wdata  out  32  lane-replicated store data
dbus_wstrb  out  4  byte strobes (0000 for loads)
dbus_ack  in  1  transaction complete; rdata valid on loads
dbus_rdata  in  32  read word
out_valid  out  1  one-cycle result pulse to writeback
mem_rdata  out  32  aligned, extended load data (0 for non-loads)
alu_result_out  out  32  registered alu_result
pc_next_out  out  32  registered pc_next_in
wb_sel_out  out  2  registered
rd_out  out  5  registered
reg_we_out  out  1  registered; forced 0 on any exception
exc_misaligned  out  1  valid with out_valid: misaligned access
exc_bus_timeout  out  1  valid with out_valid: no ack within TIMEOUT_CYCLES

Behaviour:
- Reset (rst high at clk edge): state IDLE; all outputs 0 except in_ready=1; counter cleared. Reset mid-transaction drops dbus_req next cycle; no result is emitted.
- FSM states: IDLE, BUS. in_ready = (state==IDLE).
- IDLE, accept (in_valid & in_ready & ~flush):
  - mem_op none/reserved, or access misaligned: result registered; out_valid=1 next cycle; stay IDLE. Throughput 1 op/cycle.
  - Load/store, aligned: bus outputs registered; dbus_req=1 next cycle; go BUS.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0. No bus request; exc_misaligned=1, reg_we_out=0.
- BUS: dbus_req, dbus_we, dbus_addr, dbus_wdata and dbus_wstrb held stable until ack. On the dbus_ack cycle, drop req next cycle, capture and extend rdata, out_valid=1 next cycle, return to IDLE. Minimum load/store latency is accept -> out_valid in 2 cycles with a same-cycle ack.
- Timeout: the counter increments each BUS cycle without ack. When count == TIMEOUT_CYCLES, drop req and go IDLE; out_valid=1 next cycle with exc_bus_timeout=1 and reg_we_out=0. An ack arriving in the same cycle as the timeout wins, so the transaction completes normally.
- Flush: in IDLE, blocks acceptance and clears a pending out_valid. In BUS, the transaction runs to ack or timeout (the bus is not aborted), but its out_valid is suppressed.
- Store data/strobes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata=rs2, wstrb=1111.
- Load extract: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W direct.
- out_valid is a single-cycle pulse; writeback never back-pressures.

Decomposition:
- Shared header mem_defs.vh: MEM_OP_NONE/LOAD/STORE encodings, funct3 width codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU), FSM state encodings.
- Sub-module lsu_align (combinational): misalign detect, wstrb/wdata generation, load extraction/extension. It is reused later by a cache.

Test Plan:
- SB rs2=0x000000A5, addr=0x1003, ack same cycle -> dbus_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5; out_valid 2 cycles after accept; reg_we_out=0.
- LB addr=0x2001, rdata=0x1234_80FF, ack after 3 cycles -> mem_rdata=0xFFFFFF80, in_ready low for 4 cycles; the LBU variant gives 0x00000080.
- LW addr=0x3002 -> no dbus_req; out_valid next cycle with exc_misaligned=1, reg_we_out=0.
- Load with ack withheld, TIMEOUT_CYCLES=4 -> req deasserts after 4 BUS cycles; exc_bus_timeout=1; a second run with ack on the 4th cycle completes normally.
- Back-to-back ALU ops (mem_op=00), 3 consecutive -> 3 consecutive out_valid pulses, rd/pc_next match inputs.
- Flush asserted during BUS, then ack -> no out_valid; rst asserted during BUS -> dbus_req=0 next cycle, in_ready=1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the RV32I memory stage: op codes, access widths, FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_LOAD  = 2'b01,
    MEM_OP_STORE = 2'b10,
    MEM_OP_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: misalignment detect, store strobes/data, load extract and extend.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    misaligned = 1'b0;
    wstrb      = 4'b1111;
    wdata      = store_data;
    load_data  = load_word;
    shifted    = load_word >> {addr_lo, 3'b000};
    sign_ext   = ~mem_sel[2];
    case (mem_sel)
      MEM_B, MEM_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        misaligned = addr_lo[0];
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      // word access; unused funct3 codes fall back to word behaviour
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory stage: single-outstanding req/ack data bus access with stall and timeout.
//   state   | meaning
//   IDLE    | ready for a new op; non-bus ops complete here in one cycle
//   BUS     | bus request outstanding, waiting for ack or timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [1:0]  wb_sel_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  input  logic [31:0] pc_next_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        out_valid,
  output logic [31:0] mem_rdata,
  output logic [31:0] alu_result_out,
  output logic [31:0] pc_next_out,
  output logic [1:0]  wb_sel_out,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        exc_misaligned,
  output logic        exc_bus_timeout
);

  mau_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       lo_q;
  logic [2:0]       sel_q;
  logic             is_load_q;
  logic             killed_q;

  logic        is_load, is_store, is_mem, accept, start_bus, timeout_hit, report;
  logic        align_mis, misaligned;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata, align_load;

  assign is_load     = (mem_op == MEM_OP_LOAD);
  assign is_store    = (mem_op == MEM_OP_STORE);
  assign is_mem      = is_load | is_store;
  assign in_ready    = (state == ST_IDLE);
  assign accept      = in_valid & in_ready & ~flush;
  assign misaligned  = is_mem & align_mis;
  assign start_bus   = accept & is_mem & ~align_mis;
  // down-counter loaded with the limit; terminal count of 1 is the last allowed cycle
  assign timeout_hit = (state == ST_BUS) & ~dbus_ack & (TIMEOUT_CYCLES != 0)
                     & (cnt == CNT_W'(1));
  assign report      = ~(killed_q | flush);

  lsu_align u_align (
    .addr_lo    ((state == ST_BUS) ? lo_q : alu_result[1:0]),
    .mem_sel    ((state == ST_BUS) ? sel_q : mem_sel),
    .store_data (rs2_data),
    .load_word  (dbus_rdata),
    .misaligned (align_mis),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_bus) state_nxt = ST_BUS;
      ST_BUS:  if (dbus_ack | timeout_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      lo_q            <= '0;
      sel_q           <= '0;
      is_load_q       <= 1'b0;
      killed_q        <= 1'b0;
      dbus_req        <= 1'b0;
      dbus_we         <= 1'b0;
      dbus_addr       <= '0;
      dbus_wdata      <= '0;
      dbus_wstrb      <= '0;
      out_valid       <= 1'b0;
      mem_rdata       <= '0;
      alu_result_out  <= '0;
      pc_next_out     <= '0;
      wb_sel_out      <= '0;
      rd_out          <= '0;
      reg_we_out      <= 1'b0;
      exc_misaligned  <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          alu_result_out  <= alu_result;
          pc_next_out     <= pc_next_in;
          wb_sel_out      <= wb_sel_in;
          rd_out          <= rd_in;
          reg_we_out      <= reg_we_in & ~misaligned;
          exc_misaligned  <= misaligned;
          exc_bus_timeout <= 1'b0;
          mem_rdata       <= '0;
          if (start_bus) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {alu_result[31:2], 2'b00};
            dbus_wdata <= align_wdata;
            dbus_wstrb <= is_store ? align_wstrb : 4'b0000;
            cnt        <= CNT_W'(TIMEOUT_CYCLES);
            lo_q       <= alu_result[1:0];
            sel_q      <= mem_sel;
            is_load_q  <= is_load;
            killed_q   <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
      end else begin
        if (flush) killed_q <= 1'b1;
        if (dbus_ack) begin
          dbus_req  <= 1'b0;
          dbus_we   <= 1'b0;
          out_valid <= report;
          mem_rdata <= is_load_q ? align_load : 32'h0;
        end else if (timeout_hit) begin
          dbus_req        <= 1'b0;
          dbus_we         <= 1'b0;
          out_valid       <= report;
          exc_bus_timeout <= 1'b1;
          reg_we_out      <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule
